// File: rtl/n64_pkg.sv
// n64_pkg: shared definitions for the N64 controller one-wire host logic.
//   - n64_state_e    : host poller state encoding
//   - N64_CMD_POLL   : status-poll command byte
//   - N64_RESP_BITS  : length of the controller response in bits
//   - N64_BTN_* / N64_JOY_* : bit positions inside the 32-bit buttons word
package n64_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_LOW,
    ST_TX_HIGH,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_RX_SAMPLE,
    ST_RX_STOP,
    ST_DONE,
    ST_ERROR
  } n64_state_e;

  localparam logic [7:0]  N64_CMD_POLL  = 8'h01;
  localparam int unsigned N64_RESP_BITS = 32;

  // Buttons word bit map
  localparam int unsigned N64_BTN_A      = 31;
  localparam int unsigned N64_BTN_B      = 30;
  localparam int unsigned N64_BTN_Z      = 29;
  localparam int unsigned N64_BTN_START  = 28;
  localparam int unsigned N64_BTN_DU     = 27;
  localparam int unsigned N64_BTN_DD     = 26;
  localparam int unsigned N64_BTN_DL     = 25;
  localparam int unsigned N64_BTN_DR     = 24;
  localparam int unsigned N64_RSVD_HI    = 23;
  localparam int unsigned N64_RSVD_LO    = 22;
  localparam int unsigned N64_BTN_L      = 21;
  localparam int unsigned N64_BTN_R      = 20;
  localparam int unsigned N64_BTN_CU     = 19;
  localparam int unsigned N64_BTN_CD     = 18;
  localparam int unsigned N64_BTN_CL     = 17;
  localparam int unsigned N64_BTN_CR     = 16;
  localparam int unsigned N64_JOY_X_LSB  = 8;
  localparam int unsigned N64_JOY_Y_LSB  = 0;

endpackage

// File: rtl/n64_rx_sync.sv
// n64_rx_sync: 2-FF synchronizer for the raw N64 bus level plus single-cycle
// edge pulses derived from the synchronized level.
//   clk, reset_n : system clock, synchronous active-low reset
//   din          : raw bus level, asynchronous to clk
//   level        : synchronized bus level
//   fall / rise  : one-cycle pulses on synchronized falling / rising edges
module n64_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Reset to the idle (pulled-up) bus level so no edge is seen out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;
  assign rise  = ~prev & sync;

endmodule

// File: rtl/n64_poll_host.sv
// n64_poll_host: host-side poller for the N64 controller one-wire bus.
// Sends the status-poll command plus stop bit, then receives the 32-bit
// response and its stop bit and presents it on buttons.
//   clk, reset_n : system clock, synchronous active-low reset
//   start        : level, begins one poll when sampled in IDLE
//   n64_in       : raw bus level (asynchronous)
//   n64_oe       : 1 = pull bus low, 0 = release
//   busy         : poll in progress
//   valid        : one-cycle pulse when buttons is updated
//   err          : one-cycle pulse on receive timeout
//   buttons      : last good response
module n64_poll_host
  import n64_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned TIMEOUT_US  = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        n64_in,
  output logic        n64_oe,
  output logic        busy,
  output logic        valid,
  output logic        err,
  output logic [31:0] buttons
);

  localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW          = $clog2(N64_RESP_BITS);

  // Terminal counts: the timer starts at 0 on the edge that enters a phase,
  // so a phase of N cycles ends when the timer reads N-1.
  localparam logic [TW-1:0] T_1US = TW'(CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_2US = TW'(2 * CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_3US = TW'(3 * CLKS_PER_US - 1);
  localparam logic [TW-1:0] T_TO  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] LAST_BIT = RW'(N64_RESP_BITS - 1);

  n64_state_e               state;
  logic [TW-1:0]            timer;
  logic [2:0]               tx_idx;
  logic [RW-1:0]            rx_cnt;
  logic [N64_RESP_BITS-1:0] shift;
  logic                     stop_low;

  logic          rx_level;
  logic          rx_fall;
  logic          rx_rise;
  logic          cmd_bit;
  logic [TW-1:0] low_end;
  logic [TW-1:0] high_end;

  n64_rx_sync u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (n64_in),
    .level   (rx_level),
    .fall    (rx_fall),
    .rise    (rx_rise)
  );

  // 0 bit: 3 us low / 1 us high; 1 bit: 1 us low / 3 us high.
  always_comb begin
    cmd_bit  = N64_CMD_POLL[tx_idx];
    low_end  = cmd_bit ? T_1US : T_3US;
    high_end = cmd_bit ? T_3US : T_1US;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      n64_oe   <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      buttons  <= '0;
      timer    <= '0;
      tx_idx   <= '0;
      rx_cnt   <= '0;
      shift    <= '0;
      stop_low <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_TX_LOW;
            n64_oe <= 1'b1;
            busy   <= 1'b1;
            timer  <= '0;
            tx_idx <= 3'd7;
          end
        end

        ST_TX_LOW: begin
          if (timer == low_end) begin
            n64_oe <= 1'b0;
            timer  <= '0;
            state  <= ST_TX_HIGH;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_TX_HIGH: begin
          if (timer == high_end) begin
            n64_oe <= 1'b1;
            timer  <= '0;
            if (tx_idx == 3'd0) begin
              state <= ST_TX_STOP;
            end else begin
              tx_idx <= tx_idx - 3'd1;
              state  <= ST_TX_LOW;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // Stop bit is low only; the bus is released straight into receive.
        ST_TX_STOP: begin
          if (timer == T_1US) begin
            n64_oe <= 1'b0;
            timer  <= '0;
            rx_cnt <= '0;
            state  <= ST_RX_WAIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_RX_WAIT: begin
          if (rx_fall) begin
            timer <= '0;
            state <= ST_RX_SAMPLE;
          end else if (timer == T_TO) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_RX_SAMPLE: begin
          if (timer == T_2US) begin
            shift <= {shift[N64_RESP_BITS-2:0], rx_level};
            timer <= '0;
            if (rx_cnt == LAST_BIT) begin
              stop_low <= 1'b0;
              state    <= ST_RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + RW'(1);
              state  <= ST_RX_WAIT;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // Needs the stop bit's falling edge before its rising edge counts;
        // the tail of a 0 data bit rises here too and must be ignored.
        ST_RX_STOP: begin
          if (stop_low && rx_rise) begin
            buttons <= shift;
            valid   <= 1'b1;
            state   <= ST_DONE;
          end else if (rx_fall) begin
            stop_low <= 1'b1;
            timer    <= '0;
          end else if (timer == T_TO) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // valid/err pulse during these states; busy drops on the way out.
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_ERROR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          n64_oe <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_poll_host.sv
`timescale 1ns/1ps
module tb_n64_poll_host;
  import n64_pkg::*;

  localparam int CLK_NS = 10;
  localparam int US_NS  = 50 * CLK_NS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        n64_in;
  logic        n64_oe;
  logic        busy;
  logic        valid;
  logic        err;
  logic [31:0] buttons;

  logic ctl_low = 1'b0;
  logic resp_en = 1'b1;
  logic tb_ready = 1'b0;

  typedef struct packed {
    logic        is_err;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] resp_q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #(CLK_NS/2) clk = ~clk;

  // Open-drain bus with pull-up: low when either side pulls it down.
  assign n64_in = ~(n64_oe | ctl_low);

  n64_poll_host #(
    .CLKS_PER_US (50),
    .TIMEOUT_US  (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .n64_in  (n64_in),
    .n64_oe  (n64_oe),
    .busy    (busy),
    .valid   (valid),
    .err     (err),
    .buttons (buttons)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Controller model: answers after the host's 9th low pulse (8 bits + stop).
  initial begin
    logic [31:0] word;
    wait (tb_ready);
    forever begin
      repeat (9) @(negedge n64_oe);
      if (resp_en) begin
        word = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
        #(3 + 2 * US_NS);
        for (int i = 31; i >= 0; i--) begin
          ctl_low = 1'b1;
          #(word[i] ? US_NS : 3 * US_NS);
          ctl_low = 1'b0;
          #(word[i] ? 3 * US_NS : US_NS);
        end
        ctl_low = 1'b1;
        #(2 * US_NS);
        ctl_low = 1'b0;
      end
    end
  end

  // Scoreboard: every valid/err pulse pops one expected event.
  // kind: 1 = valid only, 2 = err only, 3 = both
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] kind;
    if (reset_n === 1'b1 && (valid === 1'b1 || err === 1'b1)) begin
      kind = (valid === 1'b1) ? ((err === 1'b1) ? 32'd3 : 32'd1) : 32'd2;
      if (exp_q.size() == 0) begin
        check("evt_unexpected", kind, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", kind, e.is_err ? 32'd2 : 32'd1);
        check("buttons", buttons, e.val);
      end
    end
  end

  initial begin
    #(90000 * CLK_NS);
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_end", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] word_a_start(input logic [7:0] x, input logic [7:0] y);
    logic [31:0] w = '0;
    w[N64_BTN_A]     = 1'b1;
    w[N64_BTN_START] = 1'b1;
    w[N64_JOY_X_LSB +: 8] = x;
    w[N64_JOY_Y_LSB +: 8] = y;
    return w;
  endfunction

  function automatic logic [31:0] word_all(input logic [7:0] x, input logic [7:0] y);
    logic [31:0] w = '0;
    w[N64_BTN_A] = 1'b1;  w[N64_BTN_B] = 1'b1;  w[N64_BTN_Z] = 1'b1;
    w[N64_BTN_START] = 1'b1;
    w[N64_BTN_DU] = 1'b1; w[N64_BTN_DD] = 1'b1; w[N64_BTN_DL] = 1'b1;
    w[N64_BTN_DR] = 1'b1; w[N64_BTN_L] = 1'b1;  w[N64_BTN_R] = 1'b1;
    w[N64_BTN_CU] = 1'b1; w[N64_BTN_CD] = 1'b1; w[N64_BTN_CL] = 1'b1;
    w[N64_BTN_CR] = 1'b1;
    w[N64_JOY_X_LSB +: 8] = x;
    w[N64_JOY_Y_LSB +: 8] = y;
    return w;
  endfunction

  initial begin
    int unsigned w_low;
    int unsigned w_high;
    int unsigned total;
    int unsigned cnt;
    int unsigned v;
    logic [31:0] b2b[3];

    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe",      32'(n64_oe), 32'd0);
    check("rst_busy",    32'(busy),   32'd0);
    check("rst_valid",   32'(valid),  32'd0);
    check("rst_err",     32'(err),    32'd0);
    check("rst_buttons", buttons,     32'h0);
    reset_n  = 1'b1;
    tb_ready = 1'b1;
    @(negedge clk);

    // Poll 1: A + START, X=7F, Y=80; also measure the transmit waveform.
    resp_q.push_back(word_a_start(8'h7F, 8'h80));
    exp_q.push_back('{1'b0, 32'h9000_7F80});
    pulse_start();
    check("busy_lat", 32'(busy),   32'd1);
    check("oe_lat",   32'(n64_oe), 32'd1);
    total = 0;
    for (int b = 0; b < 9; b++) begin
      w_low = 0;
      while (n64_oe === 1'b1 && w_low < 1000) begin
        w_low++;
        @(negedge clk);
      end
      check($sformatf("low_w%0d", b), w_low, (b < 7) ? 32'd150 : 32'd50);
      total += w_low;
      if (b < 8) begin
        w_high = 0;
        while (n64_oe === 1'b0 && w_high < 1000) begin
          w_high++;
          @(negedge clk);
        end
        check($sformatf("cell%0d", b), w_low + w_high, 32'd200);
        total += w_high;
      end
    end
    check("tx_total", total, 32'd1650);
    check("oe_released", 32'(n64_oe), 32'd0);
    wait_idle(12000);
    check("sb_empty1", exp_q.size(), 32'd0);

    // Poll 2: everything pressed, with a stray start pulse mid-poll.
    resp_q.push_back(word_all(8'hFF, 8'hFF));
    exp_q.push_back('{1'b0, 32'hFF3F_FFFF});
    pulse_start();
    repeat (500) @(negedge clk);
    pulse_start();
    wait_idle(12000);
    repeat (20) @(negedge clk);
    check("no_extra_poll", 32'(busy), 32'd0);
    check("sb_empty2", exp_q.size(), 32'd0);

    // Poll 3: no responder -> timeout, buttons retained.
    resp_en = 1'b0;
    exp_q.push_back('{1'b1, 32'hFF3F_FFFF});
    pulse_start();
    cnt = 1;
    while (err !== 1'b1 && cnt < 7000) begin
      @(negedge clk);
      cnt++;
    end
    check("err_time_ok", 32'(cnt >= 6647 && cnt <= 6653), 32'd1);
    @(negedge clk);
    check("busy_after_err", 32'(busy), 32'd0);
    check("buttons_kept", buttons, 32'hFF3F_FFFF);
    check("sb_empty3", exp_q.size(), 32'd0);
    resp_en = 1'b1;

    // Poll 4: reset during received bit 10, then a clean poll.
    resp_q.push_back(32'hDEAD_BEEF);
    pulse_start();
    repeat (3800) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_oe",      32'(n64_oe), 32'd0);
    check("midrst_busy",    32'(busy),   32'd0);
    check("midrst_buttons", buttons,     32'h0);
    reset_n = 1'b1;
    repeat (5000) @(negedge clk);
    resp_q.push_back(32'h1234_5678);
    exp_q.push_back('{1'b0, 32'h1234_5678});
    pulse_start();
    wait_idle(12000);
    check("sb_empty4", exp_q.size(), 32'd0);

    // Polls 5-7: start held high, response changes each poll.
    b2b[0] = 32'h8000_0001;
    b2b[1] = 32'h0830_5AA5;
    b2b[2] = 32'h4001_C33C;
    for (int i = 0; i < 3; i++) begin
      resp_q.push_back(b2b[i]);
      exp_q.push_back('{1'b0, b2b[i]});
    end
    @(negedge clk);
    start = 1'b1;
    v   = 0;
    cnt = 0;
    while (v < 3 && cnt < 30000) begin
      @(negedge clk);
      cnt++;
      if (valid === 1'b1) v++;
    end
    start = 1'b0;
    check("b2b_valids", v, 32'd3);
    wait_idle(12000);
    repeat (20) @(negedge clk);
    check("b2b_stopped", 32'(busy), 32'd0);
    check("sb_empty5", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_poll_host.md
# n64_poll_host

Synthesizable host-side poller for the N64 controller one-wire bus. On request it transmits the 8-bit status-poll command (0x01) plus a stop bit on the open-drain data line. It then releases the line, receives the controller's 32-bit button/joystick response and its stop bit, and presents the decoded word to the application logic. It sits between the FPGA pin tristate buffer and the input-handling logic.

## Interface
- CLKS_PER_US, 50: clock cycles per microsecond; all bus timing derives from this.
- TIMEOUT_US, 100: maximum time, in µs, allowed while waiting for a controller falling edge in receive.
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  level; sampled in IDLE, begins one poll.
- n64_in  in  1  raw bus level; asynchronous to clk.
- n64_oe  out  1  1 = drive bus low; 0 = release (external pull-up). Pin is driven as n64_oe ? 0 : Z outside this block.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- valid  out  1  one-cycle pulse when buttons is updated.
- err  out  1  one-cycle pulse on receive timeout.
- buttons  out  32  last good response. Bit map:
  - [31] A, [30] B, [29] Z, [28] START
  - [27:24] D-pad up/down/left/right
  - [23:22] reserved
  - [21] L, [20] R
  - [19:16] C up/down/left/right
  - [15:8] joystick X, [7:0] joystick Y

## Operation
- Reset values: n64_oe=0, busy=0, valid=0, err=0, buttons=0, state IDLE.
- State flow: IDLE -> TX_LOW <-> TX_HIGH (8 bits, MSB first) -> TX_STOP -> RX_WAIT -> RX_SAMPLE (32×) -> RX_STOP -> DONE -> IDLE. Any RX state -> ERROR -> IDLE on timeout.
- TX bit encoding (4 µs cell):
  - 0 = low 3 µs, high 1 µs.
  - 1 = low 1 µs, high 3 µs.
  - Command 0x01 = seven 0 bits, then one 1 bit.
- TX_STOP: low 1 µs, then n64_oe=0 and enter RX_WAIT. Release is immediate; no high phase is driven.
- Receive input: n64_in passes through a 2-FF synchronizer. The falling-edge detector compares the synchronized value against its previous value.
- RX_WAIT: wait for a falling edge, then enter RX_SAMPLE.
- RX_SAMPLE: exactly 2 µs after the edge, sample the line and shift it into a 32-bit shift register (first bit -> [31]), then return to RX_WAIT.
- RX_STOP: after bit 32, wait for the stop-bit falling edge, then the rising edge, then enter DONE.
- DONE: buttons <= shift register; valid pulses for one cycle.
- Timeout counter:
  - cleared on entry to RX_WAIT and on every falling edge;
  - reaching TIMEOUT_US·CLKS_PER_US in RX_WAIT or RX_STOP -> ERROR.
- ERROR: err pulses for one cycle; buttons is unchanged; partial data is discarded.
- start while busy is ignored.
- start still high on return to IDLE begins the next poll on the following cycle, so polls run back-to-back.
- n64_oe is never asserted outside the TX states.
- reset_n low in any state forces the reset values at the next clk edge, including mid-bit (bus released).

## Timing
- Values below are at CLKS_PER_US=50.
- Latency:
  - start sampled high in IDLE -> busy=1 and n64_oe=1 at the next edge.
  - TX total: 8·200 + 50 = 1650 cycles of drive activity.
- Low widths: 0 bit 150 cycles, 1 bit 50, stop 50; ±0 cycles tolerance.
- Sample point: 100 cycles after the synchronized falling edge, which is 102–103 cycles after the pin edge.
- valid and err are mutually exclusive and never asserted in the same poll.
- busy drops in the cycle after the valid or err pulse.
- Counter width: $clog2(TIMEOUT_US·CLKS_PER_US+1) bits. This bound covers both the 150-cycle bit timer and the timeout.

## Structure
- Package n64_pkg holds:
  - state enum;
  - N64_CMD_POLL = 8'h01;
  - response length 32;
  - named bit-index constants for the buttons map.
- Sub-module n64_rx_sync: 2-FF synchronizer plus falling/rising edge pulses. It is also reused by any future N64 receiver.

## Test plan
- Bench controller model with A=1, START=1, X=8'h7F, Y=8'h80 -> buttons=32'h9000_7F80, exactly one valid pulse, err never high.
- All buttons pressed, X=Y=8'hFF -> buttons=32'hFF3F_FFFF (reserved bits 0).
- Measure n64_oe low widths over one poll -> 150×7, 50, 50 cycles; bit cells 200 cycles; n64_oe=0 after cycle 1650.
- No responder (line held high by pull-up) -> err pulse 1650+5000 cycles (±3) after start; buttons keeps its previous value; busy then 0.
- reset_n low during received bit 10 -> n64_oe=0, busy=0 at the next edge. A subsequent start yields a correct frame.
- start held high for 3 polls with the response changing between polls -> 3 valid pulses with matching buttons values. A start pulse mid-poll creates no extra poll.
